// File: rtl/automata_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : automata_pkg
// Purpose  : Shared types and constants for the programmable STE-array
//            runtime monitor: config field encoding, monitor states,
//            attribute bit positions and config-word width helpers.
// Revision : 1.0  initial release
// ============================================================================
package automata_pkg;

    // Config field selector carried on cfg_field.
    typedef enum logic [1:0] {
        CFG_RANGE = 2'd0,   // lo/hi of the currently selected interval
        CFG_RSEL  = 2'd1,   // interval select for subsequent CFG_RANGE writes
        CFG_ATTR  = 2'd2,   // STE attribute bits
        CFG_ADJ   = 2'd3    // incoming-edge mask for the STE
    } cfg_field_e;

    // Monitor run state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } mon_state_e;

    // Attribute bit positions.
    localparam int ATTR_SOD = 0;   // start_of_data: may start on first symbol
    localparam int ATTR_ALL = 1;   // all_input: may start on every symbol
    localparam int ATTR_REP = 2;   // report_en
    localparam int ATTR_W   = 3;

    // Interval-select field width; at least one bit even for a single interval.
    function automatic int rsel_w(input int num_rng);
        return (num_rng > 1) ? $clog2(num_rng) : 1;
    endfunction

    // Config write-data width: wide enough for {sel, hi, lo} and an adjacency row.
    function automatic int cfg_w(input int sym_w, input int num_rng, input int num_ste);
        int w;
        w = 2 * sym_w + $clog2(num_rng) + 1;
        return (w > num_ste) ? w : num_ste;
    endfunction

endpackage : automata_pkg
`default_nettype wire

// File: rtl/automata_range_match.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : automata_range_match
// Purpose  : Compares one symbol against NUM_RNG programmable inclusive
//            intervals and ORs the results. An interval with lo > hi can
//            never hit, so it acts as an empty slot.
// Ports    : i_symbol  symbol under test
//            i_lo      packed interval lower bounds, interval k at [k*SYM_W +: SYM_W]
//            i_hi      packed interval upper bounds, same layout
//            o_match   symbol lies in at least one interval
// Revision : 1.0  initial release
// ============================================================================
module automata_range_match #(
    parameter int SYM_W   = 8,
    parameter int NUM_RNG = 2
) (
    input  logic [SYM_W-1:0]         i_symbol,
    input  logic [NUM_RNG*SYM_W-1:0] i_lo,
    input  logic [NUM_RNG*SYM_W-1:0] i_hi,
    output logic                     o_match
);

    logic [NUM_RNG-1:0] w_hit;

    genvar k;
    generate
        for (k = 0; k < NUM_RNG; k++) begin : g_rng
            assign w_hit[k] = (i_symbol >= i_lo[k*SYM_W +: SYM_W]) &&
                              (i_symbol <= i_hi[k*SYM_W +: SYM_W]);
        end
    endgenerate

    assign o_match = |w_hit;

endmodule : automata_range_match
`default_nettype wire

// File: rtl/automata_param_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : automata_param_monitor
// Purpose  : Programmable homogeneous-automaton (STE array) runtime monitor.
//            Each STE has run-time-loaded symbol intervals, attributes and an
//            adjacency row. One symbol is consumed per accept; per-STE reports
//            are registered and every non-zero report is logged with its
//            symbol index into an internal event FIFO.
// Ports    : clk, reset_n          clock, async active-low reset
//            cfg_we/ste/field/wdata config write port (IDLE only)
//            arm, stop             run control
//            drop_mode             1: drop events on full FIFO, 0: stall input
//            sym_valid/ready, symbols  symbol stream
//            report_vec, report_any    registered per-STE report
//            evt_valid/ready/data  event FIFO head, {sym_idx, report_vec}
//            overflow              sticky event-drop flag, cleared by arm
//            busy                  monitor not IDLE
// Revision : 1.0  initial release
// ============================================================================
module automata_param_monitor
    import automata_pkg::*;
#(
    parameter int NUM_STE    = 16,
    parameter int SYM_W      = 8,
    parameter int NUM_RNG    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = 16,
    localparam int STE_W     = $clog2(NUM_STE),
    localparam int CFG_W     = cfg_w(SYM_W, NUM_RNG, NUM_STE),
    localparam int EVT_W     = IDX_W + NUM_STE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [STE_W-1:0]   cfg_ste,
    input  logic [1:0]         cfg_field,
    input  logic [CFG_W-1:0]   cfg_wdata,
    input  logic               arm,
    input  logic               stop,
    input  logic               drop_mode,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [SYM_W-1:0]   symbols,
    output logic [NUM_STE-1:0] report_vec,
    output logic               report_any,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [EVT_W-1:0]   evt_data,
    output logic               overflow,
    output logic               busy
);

    localparam int RSEL_W = rsel_w(NUM_RNG);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // ------------------------------------------------------------------
    // Configuration tables
    // ------------------------------------------------------------------
    logic [NUM_RNG*SYM_W-1:0] r_lo   [NUM_STE];
    logic [NUM_RNG*SYM_W-1:0] r_hi   [NUM_STE];
    logic [RSEL_W-1:0]        r_rsel [NUM_STE];
    logic [ATTR_W-1:0]        r_attr [NUM_STE];
    logic [NUM_STE-1:0]       r_adj  [NUM_STE];

    // ------------------------------------------------------------------
    // Run state
    // ------------------------------------------------------------------
    mon_state_e         r_state;
    logic [NUM_STE-1:0] r_active;
    logic [NUM_STE-1:0] r_report;
    logic [IDX_W-1:0]   r_idx;
    logic               r_overflow;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [EVT_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic [NUM_STE-1:0] w_match;
    logic [NUM_STE-1:0] w_active_next;
    logic [NUM_STE-1:0] w_report_next;
    logic               w_busy;
    logic               w_sod;
    logic               w_full;
    logic               w_accept;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic               w_cfg_unused;

    // Only some cfg_wdata bits are meaningful for any given field.
    assign w_cfg_unused = ^cfg_wdata;

    assign w_busy    = (r_state != IDLE);
    assign w_sod     = (r_state == ARMED);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = evt_valid & evt_ready;
    // In drop mode the input never stalls; otherwise stall only while the
    // FIFO is full and the collector is not popping this cycle.
    assign sym_ready = w_busy & (drop_mode | ~(w_full & ~evt_ready));
    assign w_accept  = sym_valid & sym_ready;

    assign w_push_req = w_accept & (|w_report_next);
    // A pop in the same cycle frees the slot the push needs.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // ------------------------------------------------------------------
    // Per-STE match and next-state
    // ------------------------------------------------------------------
    genvar i;
    generate
        for (i = 0; i < NUM_STE; i++) begin : g_ste
            automata_range_match #(
                .SYM_W   (SYM_W),
                .NUM_RNG (NUM_RNG)
            ) u_match (
                .i_symbol (symbols),
                .i_lo     (r_lo[i]),
                .i_hi     (r_hi[i]),
                .o_match  (w_match[i])
            );

            assign w_active_next[i] = w_match[i] &
                                      ((w_sod & r_attr[i][ATTR_SOD]) |
                                       r_attr[i][ATTR_ALL] |
                                       (|(r_active & r_adj[i])));
            assign w_report_next[i] = w_active_next[i] & r_attr[i][ATTR_REP];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Configuration writes, honoured only while IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_STE; s++) begin
                r_lo[s]   <= '0;
                r_hi[s]   <= '0;
                r_rsel[s] <= '0;
                r_attr[s] <= '0;
                r_adj[s]  <= '0;
            end
        end else if (cfg_we && (r_state == IDLE)) begin
            case (cfg_field_e'(cfg_field))
                CFG_RANGE: begin
                    for (int k = 0; k < NUM_RNG; k++) begin
                        if (r_rsel[cfg_ste] == RSEL_W'(k)) begin
                            r_lo[cfg_ste][k*SYM_W +: SYM_W] <= cfg_wdata[SYM_W-1:0];
                            r_hi[cfg_ste][k*SYM_W +: SYM_W] <= cfg_wdata[2*SYM_W-1:SYM_W];
                        end
                    end
                end
                CFG_RSEL: r_rsel[cfg_ste] <= cfg_wdata[RSEL_W-1:0];
                CFG_ATTR: r_attr[cfg_ste] <= cfg_wdata[ATTR_W-1:0];
                CFG_ADJ:  r_adj[cfg_ste]  <= cfg_wdata[NUM_STE-1:0];
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, active vector, report register and symbol index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_active   <= '0;
            r_report   <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else if (stop) begin
            // stop outranks arm and any accept in the same cycle
            r_state  <= IDLE;
            r_active <= '0;
            r_report <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_state    <= ARMED;
                        r_idx      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ARMED, RUN: begin
                    if (w_accept) begin
                        r_state  <= RUN;
                        r_active <= w_active_next;
                        r_report <= w_report_next;
                        r_idx    <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO: the event carries the index of the reporting symbol,
    // i.e. the index value before this accept's increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                r_fifo[e] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (stop) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= {r_idx, w_report_next};
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign report_vec = r_report;
    assign report_any = |r_report;
    assign evt_valid  = (r_count != '0);
    assign evt_data   = r_fifo[r_rptr];
    assign overflow   = r_overflow;
    assign busy       = w_busy;

endmodule : automata_param_monitor
`default_nettype wire

// File: tb/tb_automata_param_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_automata_param_monitor
// Purpose  : Directed self-checking bench for automata_param_monitor with a
//            two-entry event FIFO so back-pressure and drop paths are short.
// Revision : 1.0  initial release
// ============================================================================
module tb_automata_param_monitor;

    localparam int NUM_STE    = 16;
    localparam int SYM_W      = 8;
    localparam int NUM_RNG    = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int IDX_W      = 16;
    localparam int CFG_W      = 18;
    localparam int EVT_W      = 32;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [3:0]         cfg_ste = '0;
    logic [1:0]         cfg_field = '0;
    logic [CFG_W-1:0]   cfg_wdata = '0;
    logic               arm = 1'b0;
    logic               stop = 1'b0;
    logic               drop_mode = 1'b0;
    logic               sym_valid = 1'b0;
    logic               sym_ready;
    logic [SYM_W-1:0]   symbols = '0;
    logic [NUM_STE-1:0] report_vec;
    logic               report_any;
    logic               evt_valid;
    logic               evt_ready = 1'b0;
    logic [EVT_W-1:0]   evt_data;
    logic               overflow;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    automata_param_monitor #(
        .NUM_STE    (NUM_STE),
        .SYM_W      (SYM_W),
        .NUM_RNG    (NUM_RNG),
        .FIFO_DEPTH (FIFO_DEPTH),
        .IDX_W      (IDX_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_ste    (cfg_ste),
        .cfg_field  (cfg_field),
        .cfg_wdata  (cfg_wdata),
        .arm        (arm),
        .stop       (stop),
        .drop_mode  (drop_mode),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .symbols    (symbols),
        .report_vec (report_vec),
        .report_any (report_any),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .overflow   (overflow),
        .busy       (busy)
    );

    // ---------------- stimulus helpers (inputs change 1ns after posedge) ----
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] ste, input logic [1:0] field, input logic [CFG_W-1:0] d);
        cfg_we    = 1'b1;
        cfg_ste   = ste;
        cfg_field = field;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic set_range(input logic [3:0] ste, input logic rng, input logic [7:0] lo, input logic [7:0] hi);
        cfg_write(ste, 2'd1, {17'd0, rng});
        cfg_write(ste, 2'd0, {2'b00, hi, lo});
    endtask

    task automatic do_arm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_stop;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic send(input logic [7:0] s);
        sym_valid = 1'b1;
        symbols   = s;
        tick();
        sym_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (sym_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", sym_ready); else n_pass++;
        n_total++; if (report_vec !== 16'h0) $display("FAIL reset_report: got %h want 0000", report_vec); else n_pass++;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid: got %b want 0", evt_valid); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_no_cfg;
        int bad_ready = 0;
        int bad_rep   = 0;
        int bad_evt   = 0;
        do_arm();
        n_total++; if (busy !== 1'b1) $display("FAIL arm_busy: got %b want 1", busy); else n_pass++;
        for (int k = 0; k < 256; k++) begin
            symbols   = 8'(k);
            sym_valid = 1'b1;
            #1;
            if (sym_ready !== 1'b1) bad_ready++;
            tick();
            if (report_vec !== 16'h0) bad_rep++;
            if (evt_valid !== 1'b0) bad_evt++;
        end
        sym_valid = 1'b0;
        n_total++; if (bad_ready != 0) $display("FAIL nocfg_ready: %0d cycles not ready, want 0", bad_ready); else n_pass++;
        n_total++; if (bad_rep != 0) $display("FAIL nocfg_report: %0d nonzero reports, want 0", bad_rep); else n_pass++;
        n_total++; if (bad_evt != 0) $display("FAIL nocfg_evt: %0d cycles evt_valid, want 0", bad_evt); else n_pass++;
        do_stop();
        n_total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (sym_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", sym_ready); else n_pass++;
    endtask

    task automatic test_stop_beats_arm;
        arm  = 1'b1;
        stop = 1'b1;
        tick();
        arm  = 1'b0;
        stop = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL stop_over_arm: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_chain;
        set_range(4'd0, 1'b0, 8'd0, 8'd63);
        set_range(4'd0, 1'b1, 8'd1, 8'd0);
        cfg_write(4'd0, 2'd2, 18'd1);
        set_range(4'd1, 1'b0, 8'd64, 8'd255);
        set_range(4'd1, 1'b1, 8'd1, 8'd0);
        cfg_write(4'd1, 2'd2, 18'd4);
        cfg_write(4'd1, 2'd3, 18'd1);
        drop_mode = 1'b1;
        evt_ready = 1'b0;
        do_arm();
        send(8'd10);
        n_total++; if (report_vec !== 16'h0) $display("FAIL chain_rep10: got %h want 0000", report_vec); else n_pass++;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL chain_evt10: got %b want 0", evt_valid); else n_pass++;
        send(8'd100);
        n_total++; if (report_vec !== 16'h0002) $display("FAIL chain_rep100: got %h want 0002", report_vec); else n_pass++;
        n_total++; if (report_any !== 1'b1) $display("FAIL chain_any: got %b want 1", report_any); else n_pass++;
        n_total++; if (evt_valid !== 1'b1) $display("FAIL chain_evt_valid: got %b want 1", evt_valid); else n_pass++;
        n_total++; if (evt_data !== 32'h0001_0002) $display("FAIL chain_evt_data: got %h want 00010002", evt_data); else n_pass++;
        tick();
        n_total++; if (report_vec !== 16'h0002) $display("FAIL chain_hold: got %h want 0002", report_vec); else n_pass++;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL chain_pop: evt_valid got %b want 0", evt_valid); else n_pass++;
        do_stop();
        n_total++; if (report_vec !== 16'h0) $display("FAIL chain_stop_rep: got %h want 0000", report_vec); else n_pass++;
    endtask

    task automatic test_self_loop;
        cfg_write(4'd1, 2'd2, 18'd0);
        cfg_write(4'd1, 2'd3, 18'd0);
        cfg_write(4'd0, 2'd2, 18'd5);
        cfg_write(4'd0, 2'd3, 18'd1);
        drop_mode = 1'b0;
        evt_ready = 1'b1;
        do_arm();
        send(8'd5);
        n_total++; if (report_vec !== 16'h0001) $display("FAIL loop_rep5: got %h want 0001", report_vec); else n_pass++;
        n_total++; if (evt_data !== 32'h0000_0001) $display("FAIL loop_evt5: got %h want 00000001", evt_data); else n_pass++;
        send(8'd6);
        n_total++; if (report_vec !== 16'h0001) $display("FAIL loop_rep6: got %h want 0001", report_vec); else n_pass++;
        n_total++; if (evt_data !== 32'h0001_0001) $display("FAIL loop_evt6: got %h want 00010001", evt_data); else n_pass++;
        send(8'd70);
        n_total++; if (report_vec !== 16'h0) $display("FAIL loop_rep70: got %h want 0000", report_vec); else n_pass++;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL loop_evt70: evt_valid got %b want 0", evt_valid); else n_pass++;
        send(8'd7);
        n_total++; if (report_vec !== 16'h0) $display("FAIL loop_rep7: got %h want 0000", report_vec); else n_pass++;
        evt_ready = 1'b0;
        do_stop();
    endtask

    task automatic test_back_pressure;
        cfg_write(4'd0, 2'd2, 18'd6);
        cfg_write(4'd0, 2'd3, 18'd0);
        drop_mode = 1'b0;
        evt_ready = 1'b0;
        do_arm();
        send(8'd1);
        send(8'd2);
        n_total++; if (evt_data !== 32'h0000_0001) $display("FAIL bp_head0: got %h want 00000001", evt_data); else n_pass++;
        symbols   = 8'd3;
        sym_valid = 1'b1;
        #1;
        n_total++; if (sym_ready !== 1'b0) $display("FAIL bp_stall: sym_ready got %b want 0", sym_ready); else n_pass++;
        tick();
        n_total++; if (sym_ready !== 1'b0) $display("FAIL bp_stall_hold: sym_ready got %b want 0", sym_ready); else n_pass++;
        evt_ready = 1'b1;
        #1;
        n_total++; if (sym_ready !== 1'b1) $display("FAIL bp_resume: sym_ready got %b want 1", sym_ready); else n_pass++;
        tick();
        evt_ready = 1'b0;
        sym_valid = 1'b0;
        n_total++; if (evt_data !== 32'h0001_0001) $display("FAIL bp_head1: got %h want 00010001", evt_data); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL bp_overflow: got %b want 0", overflow); else n_pass++;
        evt_ready = 1'b1;
        tick();
        n_total++; if (evt_data !== 32'h0002_0001) $display("FAIL bp_head2: got %h want 00020001", evt_data); else n_pass++;
        tick();
        n_total++; if (evt_valid !== 1'b0) $display("FAIL bp_drained: evt_valid got %b want 0", evt_valid); else n_pass++;
        evt_ready = 1'b0;
        do_stop();
    endtask

    task automatic test_drop_overflow;
        drop_mode = 1'b1;
        evt_ready = 1'b0;
        do_arm();
        send(8'd1);
        send(8'd2);
        symbols   = 8'd3;
        sym_valid = 1'b1;
        #1;
        n_total++; if (sym_ready !== 1'b1) $display("FAIL drop_ready: got %b want 1", sym_ready); else n_pass++;
        tick();
        sym_valid = 1'b0;
        n_total++; if (overflow !== 1'b1) $display("FAIL drop_overflow: got %b want 1", overflow); else n_pass++;
        n_total++; if (evt_data !== 32'h0000_0001) $display("FAIL drop_head0: got %h want 00000001", evt_data); else n_pass++;
        evt_ready = 1'b1;
        tick();
        n_total++; if (evt_data !== 32'h0001_0001) $display("FAIL drop_head1: got %h want 00010001", evt_data); else n_pass++;
        tick();
        n_total++; if (evt_valid !== 1'b0) $display("FAIL drop_drained: evt_valid got %b want 0", evt_valid); else n_pass++;
        evt_ready = 1'b0;
        do_stop();
        n_total++; if (overflow !== 1'b1) $display("FAIL drop_sticky: got %b want 1", overflow); else n_pass++;
        do_arm();
        n_total++; if (overflow !== 1'b0) $display("FAIL drop_arm_clear: got %b want 0", overflow); else n_pass++;
        do_stop();
    endtask

    task automatic test_cfg_in_run_and_stop;
        drop_mode = 1'b1;
        evt_ready = 1'b0;
        do_arm();
        send(8'd10);
        cfg_write(4'd0, 2'd2, 18'd0);
        send(8'd20);
        n_total++; if (report_vec !== 16'h0001) $display("FAIL run_cfg_ignored: got %h want 0001", report_vec); else n_pass++;
        n_total++; if (evt_valid !== 1'b1) $display("FAIL run_queued: evt_valid got %b want 1", evt_valid); else n_pass++;
        do_stop();
        n_total++; if (busy !== 1'b0) $display("FAIL stop_mid_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL stop_flush: evt_valid got %b want 0", evt_valid); else n_pass++;
        n_total++; if (report_vec !== 16'h0) $display("FAIL stop_mid_rep: got %h want 0000", report_vec); else n_pass++;
        do_arm();
        send(8'd30);
        n_total++; if (report_vec !== 16'h0001) $display("FAIL cfg_kept: got %h want 0001", report_vec); else n_pass++;
        do_stop();
    endtask

    task automatic test_reset_mid_run;
        do_arm();
        send(8'd40);
        n_total++; if (report_vec !== 16'h0001) $display("FAIL prereset_rep: got %h want 0001", report_vec); else n_pass++;
        reset_n = 1'b0;
        #2;
        n_total++; if (report_vec !== 16'h0) $display("FAIL async_reset_rep: got %h want 0000", report_vec); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy); else n_pass++;
        reset_n = 1'b1;
        tick();
        do_arm();
        send(8'd50);
        n_total++; if (report_vec !== 16'h0) $display("FAIL reset_cfg_cleared: got %h want 0000", report_vec); else n_pass++;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_cfg_evt: got %b want 0", evt_valid); else n_pass++;
        do_stop();
    endtask

    initial begin
        test_reset();
        test_no_cfg();
        test_stop_beats_arm();
        test_chain();
        test_self_loop();
        test_back_pressure();
        test_drop_overflow();
        test_cfg_in_run_and_stop();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_automata_param_monitor
`default_nettype wire
